// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// queues in-order responses with their PCs, and flushes/refetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, discard, outstanding_nxt;
    logic [31:0]   fetch_pc, resp_pc;
    logic          run;
    logic          req_fire, resp_fire, push, pop;

    // Credits cover both queued instructions and requests still in flight,
    // so every accepted request is guaranteed a queue slot.
    assign imem_req_valid = run && !redirect_valid &&
                            (({1'b0, count} + {1'b0, outstanding}) < QD);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_fire      = imem_resp_valid && (outstanding != '0);
    assign push           = resp_fire && (discard == '0) && !redirect_valid;
    assign inst_valid     = (count != '0) && !redirect_valid;
    assign pop            = inst_valid && inst_ready;
    assign inst_data      = (count != '0) ? q_data[rd_ptr] : '0;
    assign inst_pc        = (count != '0) ? q_pc[rd_ptr]   : '0;

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                resp_pc  <= redirect_pc & 32'hFFFF_FFFC;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_fire && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_resp_data;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule
